// File: rtl/mips_arb_pkg.sv
// Shared definitions for the MIPS fetch/data memory arbiter: FSM encoding and default sizing.
// Holds no logic, so it adds no latency and applies no backpressure.
package mips_arb_pkg;

   localparam int ADDR_W_DEF     = 10;
   localparam int STARVE_MAX_DEF = 4;
   localparam int STARVE_W       = 3;

   typedef enum logic [1:0] {
      IDLE,
      IF_ACC,
      DM_ACC,
      RESP
   } arb_state_t;

endpackage

// File: rtl/mips_arb_starve_cnt.sv
// Counts consecutive data grants that overtook a waiting fetch; at_max is decoded from the register in the same cycle.
// Backpressure: none; it only observes grant events and never stalls anything.
module mips_arb_starve_cnt
   import mips_arb_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic clk1,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic at_max
);

   logic [STARVE_W-1:0] cnt;

   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + STARVE_W'(1);
      end
   end

   assign at_max = (cnt == STARVE_W'(STARVE_MAX));

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one single-port memory between fetch and data stages; grant is combinational, rvalid follows two cycles later at best.
// Backpressure: requesters hold until gnt; mem_ready=0 stretches the access indefinitely.
module mips_mem_arbiter
   import mips_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [31:0]       dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [31:0]       dm_rdata,
   input  logic              halt,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic              busy
);

   arb_state_t        state, state_nxt;
   logic              owner_dm;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [31:0]       wdata_q;
   logic              if_elig;
   logic              grant_if;
   logic              grant_dm;
   logic              starve_hit;

   mips_arb_starve_cnt #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clk1   (clk1),
      .rst_n  (rst_n),
      .inc    (grant_dm & if_elig),
      .clr    (grant_if | (grant_dm & ~if_elig)),
      .at_max (starve_hit)
   );

   always_comb begin
      if_elig   = if_req & ~halt;
      grant_if  = 1'b0;
      grant_dm  = 1'b0;
      state_nxt = state;
      // Grants are suppressed while reset is asserted so nothing is handed out to a dying access.
      if (state == IDLE && rst_n) begin
         grant_if = if_elig & (~dm_req | starve_hit);
         grant_dm = dm_req & ~grant_if;
      end
      case (state)
         IDLE: begin
            if (grant_if)      state_nxt = IF_ACC;
            else if (grant_dm) state_nxt = DM_ACC;
         end
         IF_ACC, DM_ACC: begin
            if (mem_ready) state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner_dm <= 1'b0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         if_rdata <= '0;
         dm_rdata <= '0;
      end else begin
         state <= state_nxt;
         if (grant_if) begin
            owner_dm <= 1'b0;
            addr_q   <= if_addr;
            we_q     <= 1'b0;
         end else if (grant_dm) begin
            owner_dm <= 1'b1;
            addr_q   <= dm_addr;
            we_q     <= dm_we;
            wdata_q  <= dm_wdata;
         end
         if (state == IF_ACC && mem_ready) begin
            if_rdata <= mem_rdata;
         end
         // Write completions leave dm_rdata untouched.
         if (state == DM_ACC && mem_ready && !we_q) begin
            dm_rdata <= mem_rdata;
         end
      end
   end

   assign if_gnt    = grant_if;
   assign dm_gnt    = grant_dm;
   assign mem_en    = (state == IF_ACC) || (state == DM_ACC);
   assign mem_we    = (state == DM_ACC) && we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign if_rvalid = (state == RESP) && !owner_dm;
   assign dm_rvalid = (state == RESP) && owner_dm;
   assign busy      = (state != IDLE);

endmodule

// File: doc/mips_mem_arbiter.md
MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the shared memory.
REQ-002 Parameter STARVE_MAX, default 4, maximum consecutive data grants while a fetch is pending.
REQ-003 Port clk1  input  1  sole clock, all state on rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port if_req / if_addr  input  1 / ADDR_W  instruction-fetch read request and word address.
REQ-006 Port if_gnt / if_rvalid / if_rdata  output  1 / 1 / 32  fetch grant, read-data valid pulse, read data.
REQ-007 Port dm_req / dm_we / dm_addr / dm_wdata  input  1 / 1 / ADDR_W / 32  data-stage request, write enable, address, write data.
REQ-008 Port dm_gnt / dm_rvalid / dm_rdata  output  1 / 1 / 32  data grant, completion pulse (read data or write ack), read data.
REQ-009 Port halt  input  1  processor halted; masks fetch requests.
REQ-010 Port mem_en / mem_we / mem_addr / mem_wdata  output  1 / 1 / ADDR_W / 32  shared single-port memory command.
REQ-011 Port mem_rdata / mem_ready  input  32 / 1  memory read data, access-complete (wait states allowed).
REQ-012 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, IF_ACC, DM_ACC, RESP.
REQ-014 In IDLE with an eligible request, the arbiter SHALL assert exactly one of if_gnt/dm_gnt combinationally that cycle, latch address/we/wdata and owner, and enter IF_ACC or DM_ACC.
REQ-015 Requesters SHALL hold req, addr, we, wdata stable until gnt; gnt SHALL never be asserted outside IDLE.
REQ-016 In IF_ACC/DM_ACC mem_en SHALL be 1 with latched address; mem_we SHALL be 1 only in DM_ACC with latched dm_we=1; mem_en SHALL be 0 in IDLE and RESP.
REQ-017 On the ACC cycle with mem_ready=1, mem_rdata SHALL be captured into the owner's rdata register and the FSM SHALL enter RESP; mem_ready=0 SHALL hold the ACC state indefinitely.
REQ-018 In RESP the owner's rvalid SHALL pulse for exactly one cycle, then FSM returns to IDLE; rdata SHALL hold its value until the next capture for that owner.
REQ-019 Minimum latency: req/gnt cycle N, mem_en N+1, mem_ready N+1, rvalid N+2, next grant N+3.
REQ-020 Priority: dm_req SHALL win over if_req when both are eligible, except per REQ-021.
REQ-021 A 3-bit starvation counter SHALL increment on each dm grant made while if_req is eligible, clear on any if grant or any dm grant with if_req ineligible; when it equals STARVE_MAX, the next contested arbitration SHALL grant fetch.
REQ-022 halt=1 SHALL make if_req ineligible; an in-flight fetch SHALL still complete with if_rvalid; data requests SHALL be unaffected.
REQ-023 dm write completion SHALL pulse dm_rvalid; dm_rdata on writes SHALL hold its previous value.
REQ-024 Requests arriving during ACC or RESP SHALL wait; none SHALL be dropped while held.

Reset
REQ-025 With rst_n=0 at a clock edge: state=IDLE, starvation counter=0, all gnt/rvalid/mem_en/mem_we/busy=0, rdata registers=0, latched address/wdata=0.
REQ-026 Reset mid-access SHALL abandon the access: mem_en=0 from the next cycle, no rvalid issued.

Structure
REQ-027 Package mips_arb_pkg SHALL hold the FSM state enum, default ADDR_W and STARVE_MAX constants.
REQ-028 The starvation counter SHALL be a sub-module mips_arb_starve_cnt; everything else in one module.

Verification
REQ-029 Single fetch: if_req, if_addr=0, mem returns 32'h280a00c8 with mem_ready=1 at N+1 -> if_gnt at N, if_rvalid at N+2, if_rdata=32'h280a00c8.
REQ-030 Data read with 3 wait states: dm_req, dm_we=0, dm_addr=200, Mem[200]=7 -> mem_en high 4 cycles, dm_rvalid once, dm_rdata=7.
REQ-031 Write: dm_we=1, dm_addr=198, dm_wdata=5040 -> one cycle mem_we=1 with mem_addr=198, mem_wdata=5040, dm_rvalid pulse; if_req held meanwhile gets gnt only after RESP.
REQ-032 Contention: if_req and dm_req held continuously, STARVE_MAX=4 -> grant sequence dm,dm,dm,dm,if,dm,...
REQ-033 halt asserted during IF_ACC -> fetch completes with if_rvalid; thereafter if_req ignored, dm_req still serviced.
REQ-034 rst_n=0 during DM_ACC with mem_ready=0 -> next cycle mem_en=0, busy=0, no dm_rvalid.
